mem_bus_master: RTL and testbench
=================================

# mem_bus_master

Initiator for the 16×8 data memory bus. Accepts single- or multi-beat read/write requests from the control unit through a valid/ready handshake. Sequences `address_bus`, `mem_enable`, `read_write` and `data_bus_in` into the memory one beat per cycle, and returns read data from `data_bus_out` with a fixed one-cycle lag. Sits between the control unit and the `memory` block; its memory-side ports connect to that block by name.

## Interface
- `ADDR_W`, 4: memory address width; 16 locations.
- `DATA_W`, 8: data width.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle and accepting.
- `req_rw` in 1: 1 = read, 0 = write.
- `req_addr` in `ADDR_W`: start address.
- `req_len` in 4: beat count minus 1 (0..15 means 1..16 beats).
- `wr_data` in `DATA_W`: write beat data.
- `wr_valid` in 1: write beat present.
- `wr_ready` out 1: write beat accepted.
- `rd_data` out `DATA_W`: read beat data.
- `rd_valid` out 1: read beat valid. There is no backpressure on this output.
- `done` out 1: one-cycle pulse at the end of a transfer.
- `address_bus` out `ADDR_W`: memory address.
- `mem_enable` out 1: memory access strobe.
- `read_write` out 1: 1 = read, 0 = write.
- `data_bus_in` out `DATA_W`: write data to memory.
- `data_bus_out` in `DATA_W`: read data from memory.

## Operation
**Memory contract**
- Memory samples on the rising edge while `mem_enable`=1.
- Write (`read_write`=0): `mem[address_bus] <= data_bus_in`.
- Read (`read_write`=1): `data_bus_out <= mem[address_bus]`; the value is visible the cycle after the issuing edge.

**States:** IDLE, WRITE, READ, DONE. Registered state: `cur_addr` (4b), `beats_left` (4b), `rd_pend` (1b).

**IDLE**
- Drives `req_ready`=1, `mem_enable`=0, `read_write`=1.
- On `req_valid`=1: latch `cur_addr`←`req_addr` and `beats_left`←`req_len`.
- Go to READ if `req_rw`=1, else to WRITE.

**WRITE**
- `wr_ready`=1, `read_write`=0, `address_bus`=`cur_addr`.
- `data_bus_in`=`wr_data` (combinational).
- `mem_enable`=`wr_valid`.
- On a beat (`wr_valid`=1):
  - `cur_addr`←`cur_addr`+1 mod 16.
  - If `beats_left`=0, go to DONE; else decrement `beats_left`.
- `wr_valid`=0 stalls the transfer with no memory access.

**READ**
- `mem_enable`=1, `read_write`=1, `address_bus`=`cur_addr`: one beat every cycle, no stalls.
- `rd_pend`←1 each READ cycle.
- `cur_addr` and `beats_left` update as in WRITE; after the last beat, go to DONE.

**DONE**
- `done`=1 for exactly one cycle, `req_ready`=0, `mem_enable`=0.
- Next state is IDLE.

**Read return**
- `rd_valid`=`rd_pend`.
- `rd_data`=`data_bus_out` when `rd_valid`=1, else 0.
- `rd_pend` clears in any cycle not in READ.

**Idle-value rules**
- Outside WRITE: `wr_ready`=0 and `data_bus_in`=0.
- Outside READ/WRITE: `address_bus`=0 and `read_write`=1.

**Boundaries**
- `req_len`=15 performs a full 16-beat sweep.
- Address wraps from 15 to 0, e.g. start 14, len 3 → addresses 14, 15, 0, 1.
- `req_valid` while not IDLE is ignored; the requester holds it until `req_ready`.
- `wr_valid` outside WRITE is ignored.
- A new request is accepted only in IDLE. There is no back-to-back acceptance from DONE.

**Reset**
- While `reset`=1 and on the edge it deasserts, the block is in IDLE.
- Reset values: `req_ready`=1, `wr_ready`=0, `rd_valid`=0, `rd_data`=0, `done`=0, `mem_enable`=0, `read_write`=1, `address_bus`=0, `data_bus_in`=0; all counters 0.
- Reset mid-transfer aborts immediately: no further `mem_enable` and no `done`. Beats already written remain in memory.

## Timing
- Request accepted at the edge ending cycle 0 (`req_valid` & `req_ready`).
- Read of N beats:
  - Issue cycles 1..N.
  - `rd_valid` in cycles 2..N+1.
  - DONE in cycle N+1, so `done` coincides with the last `rd_valid`.
  - IDLE (`req_ready`=1) in cycle N+2.
- Write of N beats with `wr_valid` held high:
  - Memory writes in cycles 1..N.
  - DONE in cycle N+1; IDLE in cycle N+2.
  - Each cycle with `wr_valid`=0 adds one cycle.
- The first memory access is always the cycle after acceptance; there is no combinational path from `req_*` to memory outputs.

## Test plan
- Reset: assert `reset` for 2 cycles mid-idle → all outputs at reset values; `req_ready`=1 the cycle after release.
- Single write then read: write addr 5, len 0, data 0x0F → exactly one `mem_enable` cycle with `read_write`=0, `address_bus`=5; read addr 5 → `rd_valid` one cycle, `rd_data`=0x0F, `done` in the same cycle.
- Burst wrap: write addr 14, len 3, data 0xA0..0xA3 → addresses 14, 15, 0, 1; read back addr 14, len 3 → `rd_data` 0xA0, 0xA1, 0xA2, 0xA3 on 4 consecutive cycles.
- Write stall: len 2, `wr_valid` pattern 1,0,1,1 → `mem_enable` high only on valid cycles; `done` in cycle 5; memory holds all three beats.
- Busy ignore: `req_valid` asserted during a read burst with different addr → no effect until IDLE, then accepted with its own addr.
- Reset mid-write of len 7 after 3 beats → `mem_enable` drops the same cycle, no `done`, beats 0..2 present, remaining locations unchanged.

Source files
------------

// File: rtl/mem_bus_master.sv
// Bus initiator for the 16x8 data memory: turns single/multi-beat requests into
// one memory access per cycle and returns read data with a one-cycle lag.
module mem_bus_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic [ADDR_W-1:0] address_bus,
  output logic              mem_enable,
  output logic              read_write,
  output logic [DATA_W-1:0] data_bus_in,
  input  logic [DATA_W-1:0] data_bus_out
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t            state, state_next, out_state;
  logic [ADDR_W-1:0] cur_addr, cur_addr_next;
  logic [3:0]        beats_left, beats_left_next;
  logic              rd_pend, rd_pend_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
      rd_pend    <= 1'b0;
    end else begin
      state      <= state_next;
      cur_addr   <= cur_addr_next;
      beats_left <= beats_left_next;
      rd_pend    <= rd_pend_next;
    end
  end

  // Outputs decode from IDLE while reset is high so a mid-transfer reset stops
  // the memory strobe in the very cycle it is asserted.
  always_comb begin
    out_state       = reset ? IDLE : state;
    state_next      = state;
    cur_addr_next   = cur_addr;
    beats_left_next = beats_left;
    rd_pend_next    = 1'b0;
    req_ready       = 1'b0;
    wr_ready        = 1'b0;
    done            = 1'b0;
    mem_enable      = 1'b0;
    read_write      = 1'b1;
    address_bus     = '0;
    data_bus_in     = '0;

    case (out_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cur_addr_next   = req_addr;
          beats_left_next = req_len;
          state_next      = req_rw ? READ : WRITE;
        end
      end
      WRITE: begin
        wr_ready    = 1'b1;
        read_write  = 1'b0;
        address_bus = cur_addr;
        data_bus_in = wr_data;
        mem_enable  = wr_valid;
        if (wr_valid) begin
          cur_addr_next = cur_addr + ADDR_W'(1);
          if (beats_left == 4'd0) state_next = DONE;
          else beats_left_next = beats_left - 4'd1;
        end
      end
      READ: begin
        mem_enable    = 1'b1;
        address_bus   = cur_addr;
        rd_pend_next  = 1'b1;
        cur_addr_next = cur_addr + ADDR_W'(1);
        if (beats_left == 4'd0) state_next = DONE;
        else beats_left_next = beats_left - 4'd1;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rd_valid = rd_pend & ~reset;
  assign rd_data  = rd_valid ? data_bus_out : '0;

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master: a behavioural 16x8 memory, directed
// transfers that queue expected bus accesses/read beats, and a decoupled monitor.
module tb_mem_bus_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [3:0] req_addr;
  logic [3:0] req_len;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic [3:0] address_bus;
  logic       mem_enable;
  logic       read_write;
  logic [7:0] data_bus_in;
  logic [7:0] data_bus_out;

  logic [7:0]  mem [16];
  logic [7:0]  ref_mem [16];
  logic        mem_inited = 1'b0;
  logic [12:0] exp_mem [$];
  logic [7:0]  exp_rd [$];
  logic [12:0] mon_mem;
  logic [7:0]  mon_rd;
  int          n_compared = 0;
  int          n_mismatched = 0;
  int          cyc = 0;
  int          done_seen = 0;
  int          exp_done = 0;
  int          acc1, acc2;

  mem_bus_master #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .address_bus(address_bus), .mem_enable(mem_enable), .read_write(read_write),
    .data_bus_in(data_bus_in), .data_bus_out(data_bus_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory with registered read, preloaded with 0xC0+i.
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(8'hC0 + i);
      data_bus_out <= 8'h00;
      mem_inited   <= 1'b1;
    end else if (mem_enable) begin
      if (!read_write) mem[address_bus] <= data_bus_in;
      else data_bus_out <= mem[address_bus];
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every memory strobe and every read beat must match the queue head.
  always @(negedge clk) begin
    if (mem_enable === 1'b1) begin
      if (exp_mem.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_mem_access: got addr %0d rw %0b data 0x%0h, expected no access (cycle %0d)",
                 address_bus, read_write, data_bus_in, cyc);
      end else begin
        mon_mem = exp_mem.pop_front();
        check_output("mem_access{addr,rw,data}", {19'd0, address_bus, read_write, data_bus_in}, {19'd0, mon_mem});
      end
    end
    if (rd_valid === 1'b1) begin
      if (exp_rd.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_rd_valid: got data 0x%0h, expected no beat (cycle %0d)", rd_data, cyc);
      end else begin
        mon_rd = exp_rd.pop_front();
        check_output("rd_data", {24'd0, rd_data}, {24'd0, mon_rd});
      end
    end
    if (done === 1'b1) done_seen++;
  end

  // Presents a request aligned to a clock edge and holds it until accepted;
  // returns the index of the cycle that ended with the accepting edge.
  task automatic apply_stimulus(input logic rw, input logic [3:0] addr, input logic [3:0] len, output int acc_cyc);
    logic rdy;
    int   waited;
    bit   finished;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_len   = len;
    waited    = 0;
    finished  = 0;
    while (!finished) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk); #1;
      if (rdy === 1'b1) finished = 1;
      else begin
        waited++;
        if (waited > 100) begin
          check_output("accept_timeout", 32'd0, 32'd1);
          finished = 1;
        end
      end
    end
    acc_cyc   = cyc - 1;
    req_valid = 1'b0;
  endtask

  task automatic queue_read(input logic [3:0] addr, input logic [3:0] len);
    logic [3:0] a;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 4'(i);
      exp_mem.push_back({a, 1'b1, 8'h00});
      exp_rd.push_back(ref_mem[a]);
    end
    exp_done++;
  endtask

  task automatic read_burst(input logic [3:0] addr, input logic [3:0] len);
    int acc;
    queue_read(addr, len);
    apply_stimulus(1'b1, addr, len, acc);
    repeat (int'(len) + 1) @(negedge clk);
    @(negedge clk);
    check_output("read_done_pulse", {31'd0, done}, 32'd1);
    check_output("read_last_valid_with_done", {31'd0, rd_valid}, 32'd1);
    @(negedge clk);
    check_output("read_back_to_idle", {31'd0, req_ready}, 32'd1);
    check_output("rd_data_zero_when_invalid", {24'd0, rd_data}, 32'd0);
  endtask

  // pat bit k is wr_valid in cycle k+1 after acceptance; data is base + beat*step.
  task automatic write_burst(input logic [3:0] addr, input logic [3:0] len,
                             input logic [7:0] base, input logic [7:0] step, input logic [31:0] pat);
    int         acc, k, beats;
    logic [3:0] a;
    logic [7:0] d;
    exp_done++;
    apply_stimulus(1'b0, addr, len, acc);
    k = 0;
    beats = 0;
    while (beats <= int'(len) && k < 32) begin
      d = 8'(base + 8'(beats) * step);
      wr_valid = pat[k];
      wr_data  = pat[k] ? d : 8'hEE;
      if (pat[k]) begin
        a = addr + 4'(beats);
        exp_mem.push_back({a, 1'b0, d});
        ref_mem[a] = d;
        beats++;
      end
      @(posedge clk); #1;
      k++;
    end
    wr_valid = 1'b0;
    @(negedge clk);
    check_output("write_done_pulse", {31'd0, done}, 32'd1);
    @(negedge clk);
    check_output("write_back_to_idle", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check_output({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd0);
    check_output({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    check_output({tag, "_rd_data"}, {24'd0, rd_data}, 32'd0);
    check_output({tag, "_done"}, {31'd0, done}, 32'd0);
    check_output({tag, "_mem_enable"}, {31'd0, mem_enable}, 32'd0);
    check_output({tag, "_read_write"}, {31'd0, read_write}, 32'd1);
    check_output({tag, "_address_bus"}, {28'd0, address_bus}, 32'd0);
    check_output({tag, "_data_bus_in"}, {24'd0, data_bus_in}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(8'hC0 + i);
    reset     = 1'b1;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_addr  = 4'd0;
    req_len   = 4'd0;
    wr_data   = 8'h00;
    wr_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    // Reset for 2 cycles mid-idle with write-side inputs toggled.
    #1;
    reset    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset    = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    check_output("req_ready_after_reset", {31'd0, req_ready}, 32'd1);
    check_output("wr_ready_idle", {31'd0, wr_ready}, 32'd0);

    // Single write then read.
    write_burst(4'd5, 4'd0, 8'h0F, 8'h00, 32'hFFFF_FFFF);
    read_burst(4'd5, 4'd0);

    // Burst with address wrap.
    write_burst(4'd14, 4'd3, 8'hA0, 8'h01, 32'hFFFF_FFFF);
    read_burst(4'd14, 4'd3);

    // Write stall: wr_valid 1,0,1,1 for three beats.
    write_burst(4'd3, 4'd2, 8'h31, 8'h01, 32'hFFFF_FFFD);
    read_burst(4'd3, 4'd2);

    // Request held during a busy read must wait for IDLE and keep its own addr.
    queue_read(4'd0, 4'd3);
    queue_read(4'd9, 4'd0);
    apply_stimulus(1'b1, 4'd0, 4'd3, acc1);
    apply_stimulus(1'b1, 4'd9, 4'd0, acc2);
    check_output("busy_accept_gap", 32'(acc2 - acc1), 32'd6);
    @(negedge clk);
    @(negedge clk);
    check_output("busy_second_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check_output("busy_second_idle", {31'd0, req_ready}, 32'd1);

    // Full 16-beat sweep.
    write_burst(4'd0, 4'd15, 8'h03, 8'h07, 32'hFFFF_FFFF);
    read_burst(4'd0, 4'd15);

    // Reset after 3 beats of an 8-beat write.
    begin
      int acc;
      apply_stimulus(1'b0, 4'd8, 4'd7, acc);
      for (int k = 0; k < 3; k++) begin
        wr_valid = 1'b1;
        wr_data  = 8'(8'h50 + k);
        exp_mem.push_back({4'(4'd8 + 4'(k)), 1'b0, wr_data});
        ref_mem[4'd8 + 4'(k)] = wr_data;
        @(posedge clk); #1;
      end
      reset   = 1'b1;
      wr_data = 8'h53;
      @(negedge clk);
      check_output("abort_mem_enable", {31'd0, mem_enable}, 32'd0);
      check_output("abort_done", {31'd0, done}, 32'd0);
      check_output("abort_wr_ready", {31'd0, wr_ready}, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset    = 1'b0;
      wr_valid = 1'b0;
      @(negedge clk);
      check_output("abort_idle_after_release", {31'd0, req_ready}, 32'd1);
      check_output("abort_done_after_release", {31'd0, done}, 32'd0);
    end
    read_burst(4'd8, 4'd7);

    repeat (3) @(negedge clk);
    check_output("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
    check_output("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    check_output("done_pulse_count", 32'(done_seen), 32'(exp_done));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
